// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_t;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    localparam int ZERO_REG             = 0;
    localparam int REDIRECT_BUBBLES_MAX = 7;
    localparam int BUBBLE_CNT_W         = $clog2(REDIRECT_BUBBLES_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Purpose  : Hazard inputs and stage enable/flush outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  imem_valid;
    logic                  dmem_busy;

    logic                  pc_ena;
    logic                  if_id_ena;
    logic                  if_id_flush;
    logic                  id_ex_ena;
    logic                  id_ex_flush;
    logic                  ex_mem_ena;
    logic [1:0]            ctrl_state;
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_flush_cnt;

    // Controller side
    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_valid, dmem_busy,
        output pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush,
               ex_mem_ena, ctrl_state, perf_stall_cnt, perf_flush_cnt
    );

    // Pipeline side
    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_valid, dmem_busy,
        input  pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush,
               ex_mem_ena, ctrl_state, perf_stall_cnt, perf_flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use comparator between the ID and EX stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [REG_ADDR_W-1:0] id_rs1,
    input  wire logic [REG_ADDR_W-1:0] id_rs2,
    input  wire logic                  id_uses_rs1,
    input  wire logic                  id_uses_rs2,
    input  wire logic [REG_ADDR_W-1:0] ex_rd,
    input  wire logic                  ex_mem_read,
    output logic                       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard  = ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage core. Optional performance
//            counters are built when HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pipeline_hazard_ctrl_if.master hz
);

    if (REDIRECT_BUBBLES < 0 || REDIRECT_BUBBLES > REDIRECT_BUBBLES_MAX) begin : g_bad_bubbles
        $error("REDIRECT_BUBBLES out of range");
    end

    ctrl_state_t             state;
    ctrl_state_t             state_n;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_n;
    logic                    pend_redir;
    logic                    pend_redir_n;

    logic load_use;
    logic redirect_req;
    logic pc_ena;
    logic if_id_ena;
    logic if_id_flush;
    logic id_ex_ena;
    logic id_ex_flush;
    logic ex_mem_ena;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs1 (hz.id_uses_rs1),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_rd       (hz.ex_rd),
        .ex_mem_read (hz.ex_mem_read),
        .hazard      (load_use)
    );

    // A redirect deferred by a busy data memory replays on the first free cycle
    assign redirect_req = hz.ex_branch_taken || ((state == ST_MEM_WAIT) && pend_redir);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            bubble_cnt <= '0;
            pend_redir <= 1'b0;
        end else begin
            state      <= state_n;
            bubble_cnt <= bubble_cnt_n;
            pend_redir <= pend_redir_n;
        end
    end

    always_comb begin
        pc_ena       = 1'b1;
        if_id_ena    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_ena    = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_ena   = 1'b1;
        state_n      = state;
        bubble_cnt_n = bubble_cnt;
        pend_redir_n = pend_redir;

        if (reset) begin
            pc_ena      = 1'b0;
            if_id_ena   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_ena   = 1'b0;
            id_ex_flush = 1'b1;
            ex_mem_ena  = 1'b0;
        end else if (hz.dmem_busy) begin
            pc_ena     = 1'b0;
            if_id_ena  = 1'b0;
            id_ex_ena  = 1'b0;
            ex_mem_ena = 1'b0;
            state_n    = ST_MEM_WAIT;
            if (hz.ex_branch_taken) begin
                pend_redir_n = 1'b1;
            end
        end else if (redirect_req) begin
            if_id_flush  = 1'b1;
            id_ex_ena    = 1'b0;
            id_ex_flush  = 1'b1;
            pend_redir_n = 1'b0;
            bubble_cnt_n = BUBBLE_CNT_W'(REDIRECT_BUBBLES);
            state_n      = (REDIRECT_BUBBLES > 0) ? ST_REDIRECT : ST_RUN;
        end else if (state == ST_REDIRECT) begin
            if_id_flush  = 1'b1;
            bubble_cnt_n = bubble_cnt - BUBBLE_CNT_W'(1);
            if (bubble_cnt <= BUBBLE_CNT_W'(1)) begin
                state_n = ST_RUN;
            end
        end else begin
            // RUN, or MEM_WAIT released without a pending redirect
            state_n = ST_RUN;
            if (load_use) begin
                pc_ena      = 1'b0;
                if_id_ena   = 1'b0;
                id_ex_ena   = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!hz.imem_valid) begin
                pc_ena      = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    assign hz.pc_ena      = pc_ena;
    assign hz.if_id_ena   = if_id_ena;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_ena   = id_ex_ena;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.ex_mem_ena  = ex_mem_ena;
    assign hz.ctrl_state  = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_ena) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!hz.dmem_busy && redirect_req) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = stall_cnt;
    assign hz.perf_flush_cnt = flush_cnt;
`else
    assign hz.perf_stall_cnt = 32'd0;
    assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl
//            (REDIRECT_BUBBLES=2; honours HAZARD_PERF_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    // Output vector order: pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush, ex_mem_ena
    localparam logic [5:0] O_RESET  = 6'b001010;
    localparam logic [5:0] O_NORMAL = 6'b110101;
    localparam logic [5:0] O_LDUSE  = 6'b000011;
    localparam logic [5:0] O_REDIR  = 6'b111011;
    localparam logic [5:0] O_BUBBLE = 6'b111101;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_NOFET  = 6'b011101;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz_if ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W       (5),
        .REDIRECT_BUBBLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    logic [5:0] outs;
    assign outs = {hz_if.pc_ena, hz_if.if_id_ena, hz_if.if_id_flush,
                   hz_if.id_ex_ena, hz_if.id_ex_flush, hz_if.ex_mem_ena};

    task automatic set_lu(input logic on);
        hz_if.ex_mem_read = on;
        hz_if.ex_rd       = 5'd9;
        hz_if.id_rs1      = 5'd9;
        hz_if.id_uses_rs1 = 1'b1;
        hz_if.id_rs2      = 5'd1;
        hz_if.id_uses_rs2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== O_RESET || hz_if.ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL reset[%0d] outs=%b state=%0d expected outs=%b state=0",
                         i, outs, hz_if.ctrl_state, O_RESET);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORMAL || hz_if.ctrl_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release outs=%b state=%0d expected outs=%b state=0",
                     outs, hz_if.ctrl_state, O_NORMAL);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        // columns: mem_read, ex_rd, rs1, uses_rs1, rs2, uses_rs2
        logic       mr [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0] rd [6] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7, 5'd7};
        logic [4:0] r1 [6] = '{5'd3, 5'd3, 5'd3, 5'd7, 5'd7, 5'd7};
        logic       u1 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0] r2 [6] = '{5'd5, 5'd5, 5'd0, 5'd2, 5'd2, 5'd2};
        logic       u2 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0] eo [6] = '{O_LDUSE, O_NORMAL, O_NORMAL, O_NORMAL, O_LDUSE, O_NORMAL};
        for (int i = 0; i < 6; i++) begin
            hz_if.ex_mem_read = mr[i];
            hz_if.ex_rd       = rd[i];
            hz_if.id_rs1      = r1[i];
            hz_if.id_uses_rs1 = u1[i];
            hz_if.id_rs2      = r2[i];
            hz_if.id_uses_rs2 = u2[i];
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL load_use[%0d] outs=%b state=%0d expected outs=%b state=0",
                         i, outs, hz_if.ctrl_state, eo[i]);
            end
            @(negedge clk);
        end
        set_lu(1'b0);
    endtask

    task automatic test_redirect();
        logic [5:0] eo [4] = '{O_REDIR, O_BUBBLE, O_BUBBLE, O_NORMAL};
        logic [1:0] es [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            hz_if.ex_branch_taken = (i == 0);
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== es[i]) begin
                errors++;
                $display("FAIL redirect[%0d] outs=%b state=%0d expected outs=%b state=%0d",
                         i, outs, hz_if.ctrl_state, eo[i], es[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_perf_counters();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 32'd2;
        exp_flush = 32'd1;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        #1;
        checks++;
        if (hz_if.perf_stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL perf_stall got=%0d expected=%0d", hz_if.perf_stall_cnt, exp_stall);
        end
        checks++;
        if (hz_if.perf_flush_cnt !== exp_flush) begin
            errors++;
            $display("FAIL perf_flush got=%0d expected=%0d", hz_if.perf_flush_cnt, exp_flush);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_wait();
        logic [5:0] eo [8] = '{O_FREEZE, O_FREEZE, O_FREEZE, O_FREEZE,
                               O_REDIR, O_BUBBLE, O_BUBBLE, O_NORMAL};
        logic [1:0] es [8] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 8; i++) begin
            hz_if.dmem_busy       = (i < 4);
            hz_if.ex_branch_taken = (i == 0);
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== es[i]) begin
                errors++;
                $display("FAIL mem_wait[%0d] outs=%b state=%0d expected outs=%b state=%0d",
                         i, outs, hz_if.ctrl_state, eo[i], es[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_over_load_use();
        logic [5:0] eo [5] = '{O_REDIR, O_BUBBLE, O_BUBBLE, O_LDUSE, O_NORMAL};
        logic [1:0] es [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 5; i++) begin
            set_lu(i < 4);
            hz_if.ex_branch_taken = (i == 0);
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== es[i]) begin
                errors++;
                $display("FAIL branch_load_use[%0d] outs=%b state=%0d expected outs=%b state=%0d",
                         i, outs, hz_if.ctrl_state, eo[i], es[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_invalid();
        logic [5:0] eo [3] = '{O_NOFET, O_LDUSE, O_NORMAL};
        for (int i = 0; i < 3; i++) begin
            hz_if.imem_valid = (i == 2);
            set_lu(i == 1);
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL fetch_invalid[%0d] outs=%b state=%0d expected outs=%b state=0",
                         i, outs, hz_if.ctrl_state, eo[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        // Redirect restart from REDIRECT, then a busy cycle released straight into load-use
        logic       br [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       bs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       lu [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [5:0] eo [8] = '{O_REDIR, O_REDIR, O_BUBBLE, O_BUBBLE,
                               O_NORMAL, O_FREEZE, O_LDUSE, O_NORMAL};
        logic [1:0] es [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};
        for (int i = 0; i < 8; i++) begin
            hz_if.ex_branch_taken = br[i];
            hz_if.dmem_busy       = bs[i];
            set_lu(lu[i]);
            #1;
            checks++;
            if (outs !== eo[i] || hz_if.ctrl_state !== es[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] outs=%b state=%0d expected outs=%b state=%0d",
                         i, outs, hz_if.ctrl_state, eo[i], es[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset                 = 1'b1;
        hz_if.ex_branch_taken = 1'b0;
        hz_if.dmem_busy       = 1'b0;
        hz_if.imem_valid      = 1'b1;
        set_lu(1'b0);

        test_reset();
        test_load_use();
        test_redirect();
        test_perf_counters();
        test_mem_wait();
        test_branch_over_load_use();
        test_fetch_invalid();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
